// File: rtl/pe_conv1d_pkg.sv
// Shared state encoding, width helpers and saturating add for the 1-D conv PE.
package pe_conv1d_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_F,
    ST_LOAD_I,
    ST_MAC,
    ST_PSUM,
    ST_OUT,
    ST_DONE
  } state_t;

  function automatic int fl_w(input int max_f);
    return $clog2(max_f + 1);
  endfunction

  function automatic int il_w(input int max_i);
    return $clog2(max_i + 1);
  endfunction

  // Operands arrive sign-extended to 32 bits; the sum is clamped to a signed 'width'-bit range.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int width);
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = {a[31], a} + {b[31], b};
    hi = (33'sd1 <<< (width - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (width - 1));
    if (s > hi) return hi[31:0];
    if (s < lo) return lo[31:0];
    return s[31:0];
  endfunction

endpackage

// File: rtl/pe_mac.sv
// pe_mac: signed multiply-accumulate with psum-add select; PE_SAT_EN saturates each add.
// Latency: one cycle per accumulate, result visible on acc the cycle after en.
// Backpressure: none; the controller gates en/clr.
module pe_mac
  import pe_conv1d_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PSUM_W = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     sel_psum,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [PSUM_W-1:0] psum,
  output logic signed [PSUM_W-1:0] acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [PSUM_W-1:0]   addend;
  logic signed [PSUM_W-1:0]   sum;

  assign prod   = (2*DATA_W)'(a) * (2*DATA_W)'(b);
  assign addend = sel_psum ? psum : PSUM_W'(prod);

`ifdef PE_SAT_EN
  assign sum = PSUM_W'(sat_add(32'(acc), 32'(addend), PSUM_W));
`else
  assign sum = acc + addend;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/pe_conv1d_mf.sv
// pe_conv1d_mf: multi-filter strided 1-D conv PE with psum chaining; PE_SAT_EN saturates accumulates.
// Latency: F MAC cycles plus one PSUM cycle from window start to psum_out_valid.
// Backpressure: OUT holds its result until psum_out_ready; the next psum_in waits for that transfer.
module pe_conv1d_mf
  import pe_conv1d_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int PSUM_W   = 20,
  parameter int MAX_F    = 5,
  parameter int MAX_I    = 16,
  parameter int NUM_FILT = 2,
  parameter int FL_W     = fl_w(MAX_F),
  parameter int IL_W     = il_w(MAX_I)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [FL_W-1:0]   cfg_flen,
  input  logic [IL_W-1:0]   cfg_ilen,
  input  logic [IL_W-1:0]   cfg_stride,
  output logic              cfg_err,
  input  logic              filt_valid,
  output logic              filt_ready,
  input  logic [DATA_W-1:0] filt_data,
  input  logic              ifmap_valid,
  output logic              ifmap_ready,
  input  logic [DATA_W-1:0] ifmap_data,
  input  logic              psum_in_valid,
  output logic              psum_in_ready,
  input  logic [PSUM_W-1:0] psum_in_data,
  output logic              psum_out_valid,
  input  logic              psum_out_ready,
  output logic [PSUM_W-1:0] psum_out_data,
  output logic              busy,
  output logic              done
);

  localparam int FW  = (MAX_F > 1) ? $clog2(MAX_F) : 1;
  localparam int IW  = (MAX_I > 1) ? $clog2(MAX_I) : 1;
  localparam int NFW = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;
  localparam int SW  = IL_W + 2;

  state_t            state, nxt;
  logic [FL_W-1:0]   flen;
  logic [IL_W-1:0]   ilen, stride;
  logic [FW-1:0]     k_cnt;
  logic [NFW-1:0]    f_cnt;
  logic [IW-1:0]     i_cnt, w_base, rd_addr;
  logic              cfg_ok, k_last, f_last, i_last, more_win;
  logic              mac_clr, mac_en, mac_sel;
  logic [DATA_W-1:0] filt_rf  [2**NFW][2**FW];
  logic [DATA_W-1:0] ifmap_rf [2**IW];

  assign cfg_ok = (cfg_flen != '0) && (cfg_flen <= FL_W'(MAX_F)) &&
                  (cfg_ilen >= IL_W'(cfg_flen)) && (cfg_ilen <= IL_W'(MAX_I)) &&
                  (cfg_stride != '0);
  assign k_last  = (k_cnt == FW'(flen - 1'b1));
  assign f_last  = (f_cnt == NFW'(NUM_FILT - 1));
  assign i_last  = (i_cnt == IW'(ilen - 1'b1));
  assign rd_addr = w_base + IW'(k_cnt);
  // Another window fits when the next base plus the filter length stays inside the row.
  assign more_win = (SW'(w_base) + SW'(stride) + SW'(flen)) <= SW'(ilen);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt            = state;
    cfg_ready      = 1'b0;
    filt_ready     = 1'b0;
    ifmap_ready    = 1'b0;
    psum_in_ready  = 1'b0;
    psum_out_valid = 1'b0;
    done           = 1'b0;
    mac_clr        = 1'b0;
    mac_en         = 1'b0;
    mac_sel        = 1'b0;
    case (state)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid && cfg_ok) nxt = ST_LOAD_F;
      end
      ST_LOAD_F: begin
        filt_ready = 1'b1;
        if (filt_valid && k_last && f_last) nxt = ST_LOAD_I;
      end
      ST_LOAD_I: begin
        ifmap_ready = 1'b1;
        if (ifmap_valid && i_last) begin
          nxt     = ST_MAC;
          mac_clr = 1'b1;
        end
      end
      ST_MAC: begin
        mac_en = 1'b1;
        if (k_last) nxt = ST_PSUM;
      end
      ST_PSUM: begin
        psum_in_ready = 1'b1;
        if (psum_in_valid) begin
          mac_en  = 1'b1;
          mac_sel = 1'b1;
          nxt     = ST_OUT;
        end
      end
      ST_OUT: begin
        psum_out_valid = 1'b1;
        if (psum_out_ready) begin
          mac_clr = 1'b1;
          nxt     = (f_last && !more_win) ? ST_DONE : ST_MAC;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        nxt  = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flen    <= '0;
      ilen    <= '0;
      stride  <= '0;
      k_cnt   <= '0;
      f_cnt   <= '0;
      i_cnt   <= '0;
      w_base  <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_ready && cfg_valid && !cfg_ok;
      case (state)
        ST_IDLE: if (cfg_valid && cfg_ok) begin
          flen   <= cfg_flen;
          ilen   <= cfg_ilen;
          stride <= cfg_stride;
          k_cnt  <= '0;
          f_cnt  <= '0;
          i_cnt  <= '0;
          w_base <= '0;
        end
        ST_LOAD_F: if (filt_valid) begin
          k_cnt <= k_last ? '0 : k_cnt + 1'b1;
          if (k_last) f_cnt <= f_last ? '0 : f_cnt + 1'b1;
        end
        ST_LOAD_I: if (ifmap_valid) i_cnt <= i_last ? '0 : i_cnt + 1'b1;
        ST_MAC:    k_cnt <= k_last ? '0 : k_cnt + 1'b1;
        ST_OUT: if (psum_out_ready) begin
          f_cnt <= f_last ? '0 : f_cnt + 1'b1;
          if (f_last) w_base <= w_base + IW'(stride);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (filt_ready && filt_valid)   filt_rf[f_cnt][k_cnt] <= filt_data;
    if (ifmap_ready && ifmap_valid) ifmap_rf[i_cnt]       <= ifmap_data;
  end

  pe_mac #(
    .DATA_W (DATA_W),
    .PSUM_W (PSUM_W)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .clr      (mac_clr),
    .en       (mac_en),
    .sel_psum (mac_sel),
    .a        (filt_rf[f_cnt][k_cnt]),
    .b        (ifmap_rf[rd_addr]),
    .psum     (psum_in_data),
    .acc      (psum_out_data)
  );

endmodule
